reorder_buffer: RTL

8-entry circular reorder buffer for the superscalar core. Allocates a 3-bit ROB index per issued instruction and captures results from the common data bus (CDB). Commits in program order into `register_file` through its `we_in`/`wa_in`/`wd_in`/`wrob_ix_in` port. On a committed mispredict it drives `register_file` `flush_in`/`flush_addrs_in`; it also answers operand-value lookups for register-file tags with `rob_valid` set.

---
 rtl/reorder_buffer_if.sv | 46 ++++
 rtl/reorder_buffer.sv | 109 ++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Bundle of issue, CDB, lookup, commit and flush signals between the core and the reorder buffer.
// Issue has no ready: the issuer must see full_out = 0 and flush_out = 0, otherwise the request is dropped.
interface reorder_buffer_if;
  logic             issue_in;
  logic [4:0]       issue_rd_in;
  logic             issue_has_rd_in;
  logic [2:0]       rob_ix_out;
  logic             full_out;
  logic             empty_out;
  logic             cdb_valid_in;
  logic [2:0]       cdb_rob_ix_in;
  logic [31:0]      cdb_data_in;
  logic             cdb_mispredict_in;
  logic [2:0]       lk_ix1_in;
  logic [2:0]       lk_ix2_in;
  logic [31:0]      lk_val1_out;
  logic [31:0]      lk_val2_out;
  logic             lk_rdy1_out;
  logic             lk_rdy2_out;
  logic             commit_we_out;
  logic [4:0]       commit_wa_out;
  logic [31:0]      commit_wd_out;
  logic [2:0]       commit_rob_ix_out;
  logic             flush_out;
  logic [7:0][4:0]  flush_addrs_out;

  modport master (
    output issue_in, issue_rd_in, issue_has_rd_in,
    output cdb_valid_in, cdb_rob_ix_in, cdb_data_in, cdb_mispredict_in,
    output lk_ix1_in, lk_ix2_in,
    input  rob_ix_out, full_out, empty_out,
    input  lk_val1_out, lk_val2_out, lk_rdy1_out, lk_rdy2_out,
    input  commit_we_out, commit_wa_out, commit_wd_out, commit_rob_ix_out,
    input  flush_out, flush_addrs_out
  );

  modport slave (
    input  issue_in, issue_rd_in, issue_has_rd_in,
    input  cdb_valid_in, cdb_rob_ix_in, cdb_data_in, cdb_mispredict_in,
    input  lk_ix1_in, lk_ix2_in,
    output rob_ix_out, full_out, empty_out,
    output lk_val1_out, lk_val2_out, lk_rdy1_out, lk_rdy2_out,
    output commit_we_out, commit_wa_out, commit_wd_out, commit_rob_ix_out,
    output flush_out, flush_addrs_out
  );
endinterface

// File: rtl/reorder_buffer.sv
// 8-entry circular reorder buffer: in-order commit into the register file, CDB capture,
// operand lookups, and a one-cycle flush pulse after a committed mispredict.
module reorder_buffer (
  input  logic             clk_in,
  input  logic             rst_in,
  reorder_buffer_if.slave  rob
);
  localparam int DEPTH = 8;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_has_rd;
  logic [DEPTH-1:0] r_mispred;
  logic [4:0]       r_rd    [DEPTH];
  logic [31:0]      r_value [DEPTH];
  logic [2:0]       r_head;
  logic [2:0]       r_tail;
  logic [3:0]       r_count;
  logic             r_flush;
  logic [7:0][4:0]  r_flush_addrs;

  logic             w_full;
  logic             w_empty;
  logic             w_commit_fire;
  logic             w_mispredict;
  logic             w_issue_acc;
  logic             w_cdb_acc;
  logic [7:0][4:0]  w_capture;

  assign w_full        = (r_count == 4'd8);
  assign w_empty       = (r_count == 4'd0);
  assign w_commit_fire = r_valid[r_head] & r_done[r_head] & ~r_flush;
  assign w_mispredict  = w_commit_fire & r_mispred[r_head];
  assign w_issue_acc   = rob.issue_in & ~w_full & ~r_flush & ~w_mispredict;
  // A CDB write to the head being freed this cycle is dropped so the slot leaves clean.
  assign w_cdb_acc     = rob.cdb_valid_in & r_valid[rob.cdb_rob_ix_in] & ~r_flush &
                         ~(w_commit_fire & (rob.cdb_rob_ix_in == r_head));

  // Younger destinations to be squashed, oldest first; slot 7 is the instruction refused this cycle.
  always_comb begin
    w_capture = '0;
    for (int k = 0; k < 7; k++) begin
      if (r_valid[r_head + 3'(k + 1)] && r_has_rd[r_head + 3'(k + 1)])
        w_capture[k] = r_rd[r_head + 3'(k + 1)];
    end
    if (rob.issue_in && rob.issue_has_rd_in)
      w_capture[7] = rob.issue_rd_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid       <= '0;
      r_done        <= '0;
      r_has_rd      <= '0;
      r_mispred     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]    <= '0;
        r_value[i] <= '0;
      end
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_flush       <= 1'b0;
      r_flush_addrs <= '0;
    end else begin
      r_flush       <= w_mispredict;
      r_flush_addrs <= w_mispredict ? w_capture : '0;
      if (w_mispredict) begin
        r_valid <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_cdb_acc) begin
          r_done[rob.cdb_rob_ix_in]    <= 1'b1;
          r_value[rob.cdb_rob_ix_in]   <= rob.cdb_data_in;
          r_mispred[rob.cdb_rob_ix_in] <= rob.cdb_mispredict_in;
        end
        if (w_commit_fire) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + 3'd1;
        end
        if (w_issue_acc) begin
          r_valid[r_tail]   <= 1'b1;
          r_done[r_tail]    <= 1'b0;
          r_mispred[r_tail] <= 1'b0;
          r_has_rd[r_tail]  <= rob.issue_has_rd_in;
          r_rd[r_tail]      <= rob.issue_rd_in;
          r_tail            <= r_tail + 3'd1;
        end
        r_count <= r_count + {3'b000, w_issue_acc} - {3'b000, w_commit_fire};
      end
    end
  end

  assign rob.rob_ix_out        = r_tail;
  assign rob.full_out          = w_full;
  assign rob.empty_out         = w_empty;
  assign rob.lk_val1_out       = r_value[rob.lk_ix1_in];
  assign rob.lk_val2_out       = r_value[rob.lk_ix2_in];
  assign rob.lk_rdy1_out       = r_valid[rob.lk_ix1_in] & r_done[rob.lk_ix1_in];
  assign rob.lk_rdy2_out       = r_valid[rob.lk_ix2_in] & r_done[rob.lk_ix2_in];
  assign rob.commit_we_out     = w_commit_fire & r_has_rd[r_head];
  assign rob.commit_wa_out     = r_rd[r_head];
  assign rob.commit_wd_out     = r_value[r_head];
  assign rob.commit_rob_ix_out = r_head;
  assign rob.flush_out         = r_flush;
  assign rob.flush_addrs_out   = r_flush_addrs;
endmodule
